// File: rtl/mem_line_ctrl_pkg.sv
// Shared types and helpers for the memory line controller.
// Line layout: word k (k = byte addr[2:1]) lives in bits [16k+15:16k].
package mem_ctrl_pkg;

    localparam int LINE_W = 64;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        WR_ISSUE = 3'd4,
        WR_WAIT  = 3'd5,
        RESP     = 3'd6
    } state_e;

    function automatic logic [15:0] line_addr(input logic [15:0] addr);
        return {addr[15:3], 3'b000};
    endfunction

    function automatic logic [WORD_W-1:0] word_get(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        k);
        return line[{k, 4'b0000} +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] word_put(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        k,
                                                   input logic [WORD_W-1:0] w);
        logic [LINE_W-1:0] res;
        res = line;
        res[{k, 4'b0000} +: WORD_W] = w;
        return res;
    endfunction

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Bundle of the fetch port, data port, line-memory port and error flag.
// slave  : the controller
// master : the core/memory side (fetch unit, data unit, line memory)
interface mem_line_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                if_req;
    logic [15:0]         if_addr;
    logic [WORD_W-1:0]   if_data;
    logic                if_done;

    logic                dt_req;
    logic                dt_we;
    logic [15:0]         dt_addr;
    logic [WORD_W-1:0]   dt_wdata;
    logic [WORD_W-1:0]   dt_rdata;
    logic                dt_done;

    logic                mem_start;
    logic                mem_is_rd;
    logic [15:0]         mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_finish;

    logic                err;

    modport slave (
        input  if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_rdata, mem_finish,
        output if_data, if_done, dt_rdata, dt_done, mem_start, mem_is_rd, mem_addr,
               mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_rdata, mem_finish,
        input  if_data, if_done, dt_rdata, dt_done, mem_start, mem_is_rd, mem_addr,
               mem_wdata, err
    );

endinterface

// File: rtl/mem_line_ctrl_rr_arb2.sv
// Two-request round-robin arbiter (instruction vs data).
// Ports: req_if_i/req_dt_i requests, update_i commits the current grant,
//        gnt_dt_o = 1 grants data, 0 grants instruction (valid when a request is up).
// last_dt_q resets so that the first contested grant follows DATA_FIRST.
module rr_arb2 #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_if_i,
    input  logic req_dt_i,
    input  logic update_i,
    output logic gnt_dt_o
);

    logic last_dt_q;
    logic last_dt_d;

    // On a tie, grant whichever side was not granted last.
    assign gnt_dt_o  = req_dt_i && (!req_if_i || !last_dt_q);
    assign last_dt_d = update_i ? gnt_dt_o : last_dt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dt_q <= !DATA_FIRST;
        end else begin
            last_dt_q <= last_dt_d;
        end
    end

endmodule

// File: rtl/mem_line_ctrl.sv
// Sequences one 64-bit line memory for a read-only fetch port and a read/write
// data port. Word reads become line reads; word writes become read-modify-write.
// Ports: clk, rst (async, active high), bus (mem_line_ctrl_if.slave).
//
// state    | meaning
// INIT     | waiting for memory's post-reset finish pulse
// IDLE     | arbitrate and latch a request
// RD_ISSUE | line read strobe
// RD_WAIT  | waiting for read line
// WR_ISSUE | merged line write strobe
// WR_WAIT  | waiting for write completion
// RESP     | one-cycle done pulse to the owner
module mem_line_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter bit         DATA_FIRST = 1'b1,
    parameter logic [3:0] WD_CYCLES  = 4'd15
) (
    input logic            clk,
    input logic            rst,
    mem_line_ctrl_if.slave bus
);

    state_e            state_q;
    logic [3:0]        wd_q;
    logic              own_dt_q;
    logic              we_q;
    logic [1:0]        k_q;
    logic [WORD_W-1:0] wdata_q;

    logic              mem_start_q;
    logic              mem_is_rd_q;
    logic [15:0]       mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              if_done_q;
    logic [WORD_W-1:0] if_data_q;
    logic              dt_done_q;
    logic [WORD_W-1:0] dt_rdata_q;
    logic              err_q;

    logic              gnt_dt;
    logic              arb_upd;
    logic [15:0]       sel_addr;
    logic [3:0]        wd_inc;
    logic              tmo;
    logic [WORD_W-1:0] rd_word;

    rr_arb2 #(.DATA_FIRST(DATA_FIRST)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_if_i (bus.if_req),
        .req_dt_i (bus.dt_req),
        .update_i (arb_upd),
        .gnt_dt_o (gnt_dt)
    );

    assign arb_upd  = (state_q == IDLE) && (bus.if_req || bus.dt_req);
    assign sel_addr = gnt_dt ? bus.dt_addr : bus.if_addr;
    assign wd_inc   = wd_q + 4'd1;
    // A finish arriving on the terminal cycle wins over the timeout.
    assign tmo      = (wd_inc == WD_CYCLES) && !bus.mem_finish;
    // Responses carry data only for a completed read; writes and timeouts return 0.
    assign rd_word  = (state_q == RD_WAIT && bus.mem_finish) ? word_get(bus.mem_rdata, k_q)
                                                             : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            wd_q        <= '0;
            own_dt_q    <= 1'b0;
            we_q        <= 1'b0;
            k_q         <= '0;
            wdata_q     <= '0;
            mem_start_q <= 1'b0;
            mem_is_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            dt_done_q   <= 1'b0;
            dt_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (bus.mem_finish || tmo) begin
                        err_q   <= err_q | tmo;
                        wd_q    <= '0;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                IDLE: begin
                    if (bus.if_req || bus.dt_req) begin
                        own_dt_q    <= gnt_dt;
                        we_q        <= gnt_dt && bus.dt_we;
                        k_q         <= sel_addr[2:1];
                        if (gnt_dt) begin
                            wdata_q <= bus.dt_wdata;
                        end
                        mem_start_q <= 1'b1;
                        mem_is_rd_q <= 1'b1;
                        mem_addr_q  <= line_addr(sel_addr);
                        state_q     <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    mem_start_q <= 1'b0;
                    wd_q        <= '0;
                    state_q     <= RD_WAIT;
                end
                WR_ISSUE: begin
                    mem_start_q <= 1'b0;
                    wd_q        <= '0;
                    state_q     <= WR_WAIT;
                end
                RD_WAIT, WR_WAIT: begin
                    if (state_q == RD_WAIT && bus.mem_finish && we_q) begin
                        mem_wdata_q <= word_put(bus.mem_rdata, k_q, wdata_q);
                        mem_is_rd_q <= 1'b0;
                        mem_start_q <= 1'b1;
                        state_q     <= WR_ISSUE;
                    end else if (bus.mem_finish || tmo) begin
                        err_q <= err_q | tmo;
                        if (own_dt_q) begin
                            dt_done_q  <= 1'b1;
                            dt_rdata_q <= rd_word;
                        end else begin
                            if_done_q <= 1'b1;
                            if_data_q <= rd_word;
                        end
                        state_q <= RESP;
                    end else begin
                        wd_q <= wd_inc;
                    end
                end
                RESP: begin
                    if_done_q  <= 1'b0;
                    if_data_q  <= '0;
                    dt_done_q  <= 1'b0;
                    dt_rdata_q <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.mem_start = mem_start_q;
    assign bus.mem_is_rd = mem_is_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;
    assign bus.dt_done   = dt_done_q;
    assign bus.dt_rdata  = dt_rdata_q;
    assign bus.err       = err_q;

endmodule
